// File: rtl/clkdiv_pkg.sv
// Shared types and default widths for the fractional clock divider path.
package clkdiv_pkg;

    localparam int CLKDIV_INT_W  = 8;
    localparam int CLKDIV_FRAC_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [CLKDIV_INT_W-1:0]  div_int;
        logic [CLKDIV_FRAC_W-1:0] div_frac;
    } cfg_t;

endpackage

// File: rtl/clkdiv_frac_acc.sv
// Phase accumulator for dual-modulus dividers: carry selects the long period.
module clkdiv_frac_acc
    import clkdiv_pkg::*;
#(
    parameter int FRAC_W = CLKDIV_FRAC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FRAC_W-1:0] frac,
    input  logic              step,
    input  logic              clear,
    output logic              carry,
    output logic [FRAC_W-1:0] acc
);

    logic [FRAC_W:0] acc_sum;

    // Clear and step together restart the phase from zero with the new fraction.
    always_comb begin
        acc_sum = {1'b0, (clear ? {FRAC_W{1'b0}} : acc)} + {1'b0, frac};
    end

    assign carry = acc_sum[FRAC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (step) begin
            acc <= acc_sum[FRAC_W-1:0];
        end else if (clear) begin
            acc <= '0;
        end
    end

endmodule

// File: rtl/clkdiv_frac_ctrl.sv
// Fractional divider controller: config handshake, run/drain FSM, period counter
// and registered clk_div/div_tick outputs.
module clkdiv_frac_ctrl
    import clkdiv_pkg::*;
#(
    parameter int INT_W  = CLKDIV_INT_W,
    parameter int FRAC_W = CLKDIV_FRAC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [INT_W-1:0]  cfg_int,
    input  logic [FRAC_W-1:0] cfg_frac,
    output logic              cfg_err,
    output logic              busy,
    output logic              div_tick,
    output logic              clk_div
);

    state_t            state, state_nxt;
    logic              en_q;
    logic [INT_W-1:0]  act_int, pend_int, new_int;
    logic [FRAC_W-1:0] act_frac, pend_frac, new_frac, acc;
    logic [INT_W:0]    cnt, per, cnt_nxt, per_nxt, half_nxt;
    logic              boundary, xfer, legal, load_direct, load_pend, apply_pend;
    logic              new_cfg, start_period, ready_nxt, carry, acc_clear;

    always_comb begin
        boundary    = (state != IDLE) && (cnt == per - (INT_W+1)'(1));
        xfer        = cfg_valid && cfg_ready;
        legal       = (cfg_int >= INT_W'(2));
        // Configs arriving while idle or on the boundary bypass the pending slot.
        load_direct = xfer && legal && ((state == IDLE) || boundary);
        load_pend   = xfer && legal && !((state == IDLE) || boundary);
        apply_pend  = boundary && !cfg_ready;
        new_cfg     = load_direct || apply_pend;
        new_int     = load_direct ? cfg_int  : (apply_pend ? pend_int  : act_int);
        new_frac    = load_direct ? cfg_frac : (apply_pend ? pend_frac : act_frac);
        ready_nxt   = load_pend ? 1'b0 : (apply_pend ? 1'b1 : cfg_ready);

        state_nxt = state;
        case (state)
            IDLE:    if (en_q && (act_int != '0)) state_nxt = RUN;
            RUN,
            DRAIN:   begin
                if (boundary) state_nxt = en_q ? RUN : IDLE;
                else          state_nxt = en_q ? RUN : DRAIN;
            end
            default: state_nxt = IDLE;
        endcase

        start_period = (state_nxt == RUN) && ((state == IDLE) || boundary);
        acc_clear    = new_cfg || ((state_nxt == IDLE) && (acc != '0));
        per_nxt      = start_period ? ({1'b0, new_int} + (INT_W+1)'(carry)) : per;
        cnt_nxt      = (start_period || (state_nxt == IDLE)) ? '0 : cnt + (INT_W+1)'(1);
        // (P+1)>>1 without needing an extra bit when P = 2^INT_W.
        half_nxt     = (per_nxt >> 1) + (INT_W+1)'(per_nxt[0]);
    end

    clkdiv_frac_acc #(.FRAC_W(FRAC_W)) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .frac  (new_frac),
        .step  (start_period),
        .clear (acc_clear),
        .carry (carry),
        .acc   (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            en_q      <= 1'b0;
            act_int   <= '0;
            act_frac  <= '0;
            pend_int  <= '0;
            pend_frac <= '0;
            cnt       <= '0;
            per       <= '0;
            cfg_ready <= 1'b1;
        end else begin
            state     <= state_nxt;
            en_q      <= en;
            cnt       <= cnt_nxt;
            per       <= per_nxt;
            cfg_ready <= ready_nxt;
            if (new_cfg) begin
                act_int  <= new_int;
                act_frac <= new_frac;
            end
            if (load_pend) begin
                pend_int  <= cfg_int;
                pend_frac <= cfg_frac;
            end
        end
    end

    // Outputs are registered from next-state values so they line up with cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_div  <= 1'b0;
            div_tick <= 1'b0;
            cfg_err  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            clk_div  <= (state_nxt != IDLE) && (cnt_nxt < half_nxt);
            div_tick <= (state_nxt != IDLE) && (cnt_nxt == per_nxt - (INT_W+1)'(1));
            cfg_err  <= xfer && !legal;
            busy     <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_clkdiv_frac_ctrl.sv
// Directed bench for clkdiv_frac_ctrl with a per-cycle expected-output scoreboard.
module tb_clkdiv_frac_ctrl;

    localparam int INT_W  = 8;
    localparam int FRAC_W = 4;
    localparam logic [4:0] IDLE_V = 5'b00010;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [INT_W-1:0]  cfg_int = '0;
    logic [FRAC_W-1:0] cfg_frac = '0;
    logic              cfg_ready, cfg_err, busy, div_tick, clk_div;

    int         errors = 0;
    int         checks = 0;
    logic [4:0] exp_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    clkdiv_frac_ctrl #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_int   (cfg_int),
        .cfg_frac  (cfg_frac),
        .cfg_err   (cfg_err),
        .busy      (busy),
        .div_tick  (div_tick),
        .clk_div   (clk_div)
    );

    // Expected {clk_div, div_tick, busy, cfg_ready, cfg_err} at cycle c of a P-cycle period.
    function automatic logic [4:0] run_v(int c, int p, logic rdy);
        logic ck, tk;
        ck = (c < (p + 1) / 2);
        tk = (c == p - 1);
        return {ck, tk, 1'b1, rdy, 1'b0};
    endfunction

    task automatic push(logic [4:0] v, string t);
        exp_q.push_back(v);
        tag_q.push_back(t);
    endtask

    task automatic compare();
        logic [4:0] obs, expv;
        string      t;
        obs  = {clk_div, div_tick, busy, cfg_ready, cfg_err};
        expv = exp_q.pop_front();
        t    = tag_q.pop_front();
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %b expected %b (clk_div,div_tick,busy,cfg_ready,cfg_err)", t, obs, expv);
        end
    endtask

    task automatic cyc(logic [4:0] v, string t);
        push(v, t);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic period(int p, string t);
        for (int c = 0; c < p; c++) cyc(run_v(c, p, 1'b1), t);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        push(IDLE_V, "reset");
        @(posedge clk);
        #1;
        compare();
        rst_n = 1'b1;
    endtask

    task automatic start(int n, int f);
        cfg_valid = 1'b1;
        cfg_int   = INT_W'(n);
        cfg_frac  = FRAC_W'(f);
        en        = 1'b1;
        cyc(IDLE_V, "load");
        cfg_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Integer divide by 3
        do_reset();
        start(3, 0);
        period(3, "n3");
        period(3, "n3");
        period(3, "n3");

        // Illegal N=1 offered on a boundary: error pulse, pattern unchanged
        cfg_valid = 1'b1;
        cfg_int   = INT_W'(1);
        cfg_frac  = '0;
        cyc({run_v(0, 3, 1'b1)} | 5'b00001, "illegal_err");
        cfg_valid = 1'b0;
        cyc(run_v(1, 3, 1'b1), "illegal_clr");
        cyc(run_v(2, 3, 1'b1), "illegal_pat");
        period(3, "after_illegal");

        // Divide by 3.5: periods 3,4,3,4
        do_reset();
        start(3, 8);
        period(3, "frac_p3");
        period(4, "frac_p4");
        period(3, "frac_p3b");
        period(4, "frac_p4b");

        // Pending reconfig mid-period, then a config on the boundary itself
        do_reset();
        start(5, 0);
        cyc(run_v(0, 5, 1'b1), "pend_c0");
        cyc(run_v(1, 5, 1'b1), "pend_c1");
        cfg_valid = 1'b1;
        cfg_int   = INT_W'(2);
        cfg_frac  = '0;
        cyc(run_v(2, 5, 1'b0), "pend_c2");
        cfg_valid = 1'b0;
        cyc(run_v(3, 5, 1'b0), "pend_c3");
        cyc(run_v(4, 5, 1'b0), "pend_c4");
        cyc(run_v(0, 2, 1'b1), "new_p2_c0");
        cyc(run_v(1, 2, 1'b1), "new_p2_c1");
        cfg_valid = 1'b1;
        cfg_int   = INT_W'(4);
        cyc(run_v(0, 4, 1'b1), "bnd_cfg_c0");
        cfg_valid = 1'b0;
        for (int c = 1; c < 4; c++) cyc(run_v(c, 4, 1'b1), "bnd_cfg");
        period(4, "bnd_cfg_next");

        // Stop mid-period, then restart and re-raise en before the boundary
        do_reset();
        start(5, 0);
        cyc(run_v(0, 5, 1'b1), "stop_c0");
        cyc(run_v(1, 5, 1'b1), "stop_c1");
        en = 1'b0;
        cyc(run_v(2, 5, 1'b1), "stop_c2");
        cyc(run_v(3, 5, 1'b1), "stop_c3");
        cyc(run_v(4, 5, 1'b1), "stop_c4");
        cyc(IDLE_V, "drained");
        cyc(IDLE_V, "drained_hold");
        en = 1'b1;
        cyc(IDLE_V, "en_sync");
        cyc(run_v(0, 5, 1'b1), "restart_c0");
        cyc(run_v(1, 5, 1'b1), "restart_c1");
        en = 1'b0;
        cyc(run_v(2, 5, 1'b1), "drain_c2");
        cyc(run_v(3, 5, 1'b1), "drain_c3");
        en = 1'b1;
        cyc(run_v(4, 5, 1'b1), "drain_c4");
        period(5, "no_gap");

        // Widest ratio: N=255, F=8 gives periods 255 then 256
        do_reset();
        start(255, 8);
        period(255, "wide_p255");
        period(256, "wide_p256");

        // Asynchronous reset mid-period with a config pending
        do_reset();
        start(5, 0);
        cyc(run_v(0, 5, 1'b1), "rst_c0");
        cyc(run_v(1, 5, 1'b1), "rst_c1");
        cfg_valid = 1'b1;
        cfg_int   = INT_W'(2);
        cyc(run_v(2, 5, 1'b0), "rst_pend");
        cfg_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        push(IDLE_V, "async_rst");
        #1;
        compare();
        #2;
        rst_n = 1'b1;
        cyc(IDLE_V, "no_cfg_idle");
        cyc(IDLE_V, "no_cfg_idle");
        cyc(IDLE_V, "no_cfg_idle");
        start(3, 0);
        cyc(run_v(0, 3, 1'b1), "cfg_after_rst_c0");
        cyc(run_v(1, 3, 1'b1), "cfg_after_rst_c1");
        cyc(run_v(2, 3, 1'b1), "cfg_after_rst_c2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
